// File: rtl/plot_sink_fb_if.sv
// Pixel-plot stream from the game datapaths into the framebuffer sink.
// Master drives coordinates/colour/valid; slave returns ready.
interface plot_sink_fb_if;
  logic       plot_valid;
  logic       plot_ready;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;

  modport master (
    output plot_valid,
    output plot_x,
    output plot_y,
    output plot_colour,
    input  plot_ready
  );

  modport slave (
    input  plot_valid,
    input  plot_x,
    input  plot_y,
    input  plot_colour,
    output plot_ready
  );
endinterface

// File: rtl/plot_sink_fb.sv
// Plot FIFO + 160x120x3 single-port framebuffer with pixel read port and clear engine.
// Optional feature: define BOUNDS_CHECK_EN to drop out-of-range plots and count them.
module plot_sink_fb #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'd0
) (
  input  logic          clock,
  input  logic          resetn,
  plot_sink_fb_if.slave plot,
  input  logic          clear_req,
  output logic          clear_busy,
  input  logic          rd_req,
  input  logic [7:0]    rd_x,
  input  logic [6:0]    rd_y,
  output logic          rd_valid,
  output logic [2:0]    rd_colour,
  output logic [7:0]    drop_count
);

  localparam int unsigned AddrW    = 15;
  localparam int unsigned NumPix   = SCREEN_W * SCREEN_H;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NumPix - 1);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_t;

  typedef enum logic [0:0] {StRun, StClear} state_e;

  function automatic logic [AddrW-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    return AddrW'(y) * AddrW'(SCREEN_W) + AddrW'(x);
  endfunction

`ifdef BOUNDS_CHECK_EN
  function automatic logic in_bounds(input logic [7:0] x, input logic [6:0] y);
    return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Plot FIFO
  // ---------------------------------------------------------------------------
  plot_t           fifo_mem [FIFO_DEPTH];
  logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  plot_t           head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  // Ready is purely the registered fullness: a pop in the same cycle does not free a slot.
  assign plot.plot_ready = !fifo_full;
  assign push = plot.plot_valid && !fifo_full;
  assign head = fifo_mem[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= {plot.plot_x, plot.plot_y, plot.plot_colour};
  end

  // ---------------------------------------------------------------------------
  // Read request capture: one-deep, a newer request replaces the pending one
  // ---------------------------------------------------------------------------
  logic       rd_pend_q;
  logic [7:0] rd_pend_x_q;
  logic [6:0] rd_pend_y_q;
  logic       rd_any;
  logic [7:0] rd_sel_x;
  logic [6:0] rd_sel_y;
  logic [AddrW-1:0] rd_addr;
  logic       rd_oob;
  logic       rd_fire;

  assign rd_any   = rd_req || rd_pend_q;
  assign rd_sel_x = rd_req ? rd_x : rd_pend_x_q;
  assign rd_sel_y = rd_req ? rd_y : rd_pend_y_q;
  assign rd_addr  = pix_addr(rd_sel_x, rd_sel_y);

`ifdef BOUNDS_CHECK_EN
  assign rd_oob = !in_bounds(rd_sel_x, rd_sel_y);
`else
  assign rd_oob = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_pend_q   <= 1'b0;
      rd_pend_x_q <= '0;
      rd_pend_y_q <= '0;
    end else if (rd_fire) begin
      rd_pend_q <= 1'b0;
    end else if (rd_req) begin
      rd_pend_q   <= 1'b1;
      rd_pend_x_q <= rd_x;
      rd_pend_y_q <= rd_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Port arbiter / clear FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [AddrW-1:0] clear_cnt_q, clear_cnt_d;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [2:0]       mem_wdata;
  logic             head_ok;
  logic             drop;

`ifdef BOUNDS_CHECK_EN
  assign head_ok = in_bounds(head.x, head.y);
`else
  assign head_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StRun;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    rd_fire     = 1'b0;
    pop         = 1'b0;
    drop        = 1'b0;
    unique case (state_q)
      StRun: begin
        if (rd_any) begin
          rd_fire = 1'b1;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (head_ok) begin
            mem_we    = 1'b1;
            mem_waddr = pix_addr(head.x, head.y);
            mem_wdata = head.colour;
          end else begin
            drop = 1'b1;
          end
        end
        if (clear_req) begin
          state_d     = StClear;
          clear_cnt_d = '0;
        end
      end
      StClear: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_cnt_q;
        mem_wdata   = CLEAR_COLOUR;
        clear_cnt_d = clear_cnt_q + AddrW'(1);
        if (clear_cnt_q == LastAddr) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  assign clear_busy = (state_q == StClear);

  // ---------------------------------------------------------------------------
  // Framebuffer: contents are never reset
  // ---------------------------------------------------------------------------
  logic [2:0] mem [NumPix];
  logic       rd_valid_q;
  logic [2:0] rd_colour_q;

  always_ff @(posedge clock) begin
    if (mem_we && resetn) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_valid_q  <= 1'b0;
      rd_colour_q <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_colour_q <= rd_oob ? 3'd0 : mem[rd_addr];
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_colour = rd_colour_q;

  // ---------------------------------------------------------------------------
  // Dropped-plot counter
  // ---------------------------------------------------------------------------
`ifdef BOUNDS_CHECK_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hff)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign drop_count  = '0;
`endif

endmodule
